vfd_scan_capture: RTL
=====================

Name: vfd_scan_capture

Overview:
- Sits directly downstream of the ucom43 MCU core and consumes its multiplexed VFD drive outputs (grid and segment bits from ports C..I).
- Demultiplexes the scanned grid/segment stream into a per-grid row buffer with settle filtering and persistence decay.
- The video/overlay layer reads a stable frame from it through a synchronous read port.

Parameters:
- GRIDS, 10, number of grid lines (rows); 2..16.
- SEGS, 17, number of segment lines per grid.
- SETTLE, 8, clk cycles a grid+segment pattern must stay unchanged before it is latched; 2..255.
- DECAY_W, 16, width of the per-row persistence counter; a row blanks after 2^DECAY_W-1 cycles without refresh.

Ports:
- clk  in  1  system clock (same clk as the MCU core).
- _reset  in  1  asynchronous active-low reset.
- grid  in  GRIDS  grid drive from MCU ports, active high.
- seg  in  SEGS  segment drive from MCU ports, active high.
- rd_addr  in  4  grid row to read.
- rd_data  out  SEGS  segments of row rd_addr; zero if the row is decayed or rd_addr >= GRIDS.
- rd_valid  out  1  row rd_addr is lit (not decayed).
- frame_tick  out  1  one-cycle pulse at scan wrap.
- grid_idx  out  4  index of the last latched grid.

Behaviour:
- Reset (_reset low, async) clears:
  - all rows, all decay counters saturated (every row invalid);
  - rd_data, rd_valid, frame_tick, grid_idx to 0;
  - FSM to IDLE, settle counter to 0, pattern register to 0.
- Input registration: grid and seg are registered once (pat_q); all decisions use pat_q.
- Pattern change: pat_q differs from the previous cycle's pat_q, in either grid or seg.
- FSM states:
  - IDLE: grid==0. On nonzero grid -> SETTLE, cnt=0.
  - SETTLE: on pattern change, cnt=0 and stay in SETTLE (or go to IDLE if grid==0). Otherwise cnt increments. At cnt==SETTLE-1, if grid is one-hot: write seg into row[index], clear that row's decay counter, then -> HOLD. If not one-hot, -> HOLD with no write.
  - HOLD: grid==0 -> IDLE. Any other pattern change -> SETTLE, cnt=0.
- Latency:
  - A write lands SETTLE+1 cycles after the pattern first appears on the inputs (1 input register cycle + SETTLE count cycles).
  - rd_data/rd_valid are registered: 1-cycle latency from rd_addr.
- Read/write collision: a read of the row being written in the same cycle returns the old value.
- grid_idx updates on every write.
- frame_tick pulses for 1 cycle on a write whose index <= the previous written index. No pulse on the first write after reset.
- Decay:
  - Each row counter increments every cycle and saturates at all-ones.
  - A row is valid while its counter != all-ones.
  - A write resets the counter to 0. Write and saturation in the same cycle: the write wins.
- Boundary cases:
  - grid bit index >= GRIDS: not possible, since the width is GRIDS.
  - rd_addr >= GRIDS returns 0 and invalid.
  - SETTLE counter width is 8 bits and never wraps, because the transition happens at SETTLE-1.
- Reset mid-SETTLE: the pending write is discarded.

Optional Feature:
- Macro: VFD_MULTIGRID_EN.
- Defined: at settle end with more than one grid bit set, seg is written to every active row, each row's decay counter is cleared, and grid_idx takes the highest set index.
- Undefined: multi-grid patterns never write (as in the base FSM).
- The zero-grid case behaves identically either way.

Test Plan:
- Reset -> rd_valid=0 and rd_data=0 for rd_addr 0..15; frame_tick=0; grid_idx=0.
- grid=10'b0000000100, seg=17'h1A5A5 held 20 cycles, then read rd_addr=2 -> rd_data=17'h1A5A5 and rd_valid=1. The write occurs exactly SETTLE+1=9 cycles after the inputs change; grid_idx=2.
- grid=bit3 held with seg toggling every 4 cycles (shorter than SETTLE) -> no write; row 3 stays invalid.
- Scan grids 0..9 at 16 cycles each, then 0 again -> frame_tick pulses exactly once, on the second write to row 0.
- DECAY_W=4: write row 5, then no refresh for 15 cycles -> rd_valid for row 5 drops to 0 and rd_data=0. Refresh at cycle 14 keeps it valid.
- grid=10'b0000100010, seg=17'h00FF0 held 20 cycles:
  - without VFD_MULTIGRID_EN -> rows 1 and 5 unwritten;
  - with it -> both rows read 17'h00FF0 and grid_idx=5.
- Assert _reset low mid-SETTLE -> no write occurs and all outputs are 0 immediately, asynchronously.

Source files
------------

// File: rtl/vfd_scan_capture.sv
// Demultiplexes the MCU's scanned VFD grid/segment drive into a settled, decaying per-grid row buffer.
// Optional VFD_MULTIGRID_EN: a settled multi-grid pattern is written to every active row.
module vfd_scan_capture #(
   parameter int GRIDS   = 10,
   parameter int SEGS    = 17,
   parameter int SETTLE  = 8,
   parameter int DECAY_W = 16
) (
   input  logic             clk,
   input  logic             _reset,
   input  logic [GRIDS-1:0] grid,
   input  logic [SEGS-1:0]  seg,
   input  logic [3:0]       rd_addr,
   output logic [SEGS-1:0]  rd_data,
   output logic             rd_valid,
   output logic             frame_tick,
   output logic [3:0]       grid_idx
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

   localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE - 1);
   localparam logic [DECAY_W-1:0] DECAY_SAT   = '1;

   state_t              state, state_n;
   logic [7:0]          cnt, cnt_n, cnt_inc;
   logic [GRIDS-1:0]    grid_q, grid_p;
   logic [SEGS-1:0]     seg_q, seg_p;
   logic                changed, any_set, multi_set, wr_ok, wr_en, seen;
   logic [3:0]          hi_idx;
   logic [SEGS-1:0]     rows  [GRIDS];
   logic [DECAY_W-1:0]  decay [GRIDS];
   logic [SEGS-1:0]     rd_data_n;
   logic                rd_valid_n;

   assign changed = (grid_q != grid_p) || (seg_q != seg_p);
   assign cnt_inc = cnt + 8'd1;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      any_set   = 1'b0;
      multi_set = 1'b0;
      hi_idx    = 4'd0;
      for (int i = 0; i < GRIDS; i++) begin
         if (grid_q[i]) begin
            multi_set = multi_set | any_set;
            any_set   = 1'b1;
            hi_idx    = 4'(i);
         end
      end
`ifdef VFD_MULTIGRID_EN
      wr_ok = any_set;
`else
      wr_ok = any_set && !multi_set;
`endif
   end

   // The cycle that detects a new pattern counts as the first settle cycle, so the
   // write fires as the incremented count reaches SETTLE-1.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      wr_en   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (grid_q != '0) begin
               state_n = ST_SETTLE;
               cnt_n   = 8'd0;
            end
         end
         ST_SETTLE: begin
            if (changed) begin
               cnt_n = 8'd0;
               if (grid_q == '0) state_n = ST_IDLE;
            end else begin
               cnt_n = cnt_inc;
               if (cnt_inc == SETTLE_LAST) begin
                  wr_en   = wr_ok;
                  state_n = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (grid_q == '0) begin
               state_n = ST_IDLE;
            end else if (changed) begin
               state_n = ST_SETTLE;
               cnt_n   = 8'd0;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge _reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!_reset) begin
         grid_q     <= '0;
         seg_q      <= '0;
         grid_p     <= '0;
         seg_p      <= '0;
         state      <= ST_IDLE;
         cnt        <= 8'd0;
         seen       <= 1'b0;
         grid_idx   <= 4'd0;
         frame_tick <= 1'b0;
      end else begin
         grid_q     <= grid;
         seg_q      <= seg;
         grid_p     <= grid_q;
         seg_p      <= seg_q;
         state      <= state_n;
         cnt        <= cnt_n;
         frame_tick <= wr_en && seen && (hi_idx <= grid_idx);
         if (wr_en) begin
            grid_idx <= hi_idx;
            seen     <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge _reset) begin
      // NOTE: the row buffer is reset because "all rows cleared, all invalid" is observable behaviour.
      if (!_reset) begin
         for (int i = 0; i < GRIDS; i++) begin
            rows[i]  <= '0;
            decay[i] <= DECAY_SAT;
         end
      end else begin
         for (int i = 0; i < GRIDS; i++) begin
            if (wr_en && grid_q[i]) begin
               rows[i]  <= seg_q;
               decay[i] <= '0;
            end else if (decay[i] != DECAY_SAT) begin
               decay[i] <= decay[i] + 1'b1;
            end
         end
      end
   end

   // Address decode by compare keeps out-of-range rd_addr from indexing past the array.
   always_comb begin
      rd_data_n  = '0;
      rd_valid_n = 1'b0;
      for (int i = 0; i < GRIDS; i++) begin
         if (rd_addr == 4'(i)) begin
            rd_valid_n = (decay[i] != DECAY_SAT);
            rd_data_n  = rd_valid_n ? rows[i] : '0;
         end
      end
   end

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_data  <= rd_data_n;
         rd_valid <= rd_valid_n;
      end
   end

endmodule
